// File: rtl/switch_matrix_pkg.sv
// Shared side codes and load-FSM encoding for the switch matrix configuration block.
package switch_matrix_pkg;

  localparam logic [2:0] SIDE_FLOAT  = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

endpackage

// File: rtl/switch_matrix_mux.sv
// Source selector for one routed wire: picks a side/index from the side buses and
// reports whether the wire should be driven at all.
module switch_matrix_mux
  import switch_matrix_pkg::*;
#(
  parameter int NT = 5,
  parameter int NL = 4,
  parameter int IW = 3
) (
  input  logic [IW+2:0] sel,
  input  logic [NT-1:0] top,
  input  logic [NT-1:0] bottom,
  input  logic [NL-1:0] left,
  input  logic [NL-1:0] right,
  output logic          oe,
  output logic          val
);

  localparam int NP = 1 << IW;

  logic [2:0]    side;
  logic [IW-1:0] idx;
  logic [NP-1:0] top_p, bottom_p, left_p, right_p;

  assign side = sel[2:0];
  assign idx  = sel[IW+2:3];

  // Pad each side to a power of two so the index width always matches.
  assign top_p    = NP'(top);
  assign bottom_p = NP'(bottom);
  assign left_p   = NP'(left);
  assign right_p  = NP'(right);

  always_comb begin
    oe  = 1'b0;
    val = 1'b0;
    case (side)
      SIDE_TOP:    if (int'(idx) < NT) begin oe = 1'b1; val = top_p[idx];    end
      SIDE_BOTTOM: if (int'(idx) < NT) begin oe = 1'b1; val = bottom_p[idx]; end
      SIDE_LEFT:   if (int'(idx) < NL) begin oe = 1'b1; val = left_p[idx];   end
      SIDE_RIGHT:  if (int'(idx) < NL) begin oe = 1'b1; val = right_p[idx];  end
      default: ;
    endcase
  end

endmodule

// File: rtl/switch_matrix_cfg.sv
// Switch box with shadow/active routing tables loaded through a small FSM.
// state  | meaning
// IDLE   | accept writes, commit and clear requests
// CLEAR  | zero one shadow entry per cycle, index 0..NE-1
// COMMIT | copy the whole shadow table into the active table
module switch_matrix_cfg
  import switch_matrix_pkg::*;
#(
  parameter int NT = 5,
  parameter int NL = 4,
  parameter int IW = $clog2((NT > NL) ? NT : NL),
  parameter int NE = 2*NT + 2*NL,
  parameter int AW = $clog2(NE)
) (
  input  logic          clk,
  input  logic          rst,
  inout  wire  [NT-1:0] wtop,
  inout  wire  [NT-1:0] wbottom,
  inout  wire  [NL-1:0] wleft,
  inout  wire  [NL-1:0] wright,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [AW-1:0] cfg_addr,
  input  logic [IW+2:0] cfg_data,
  input  logic          cfg_commit,
  input  logic          cfg_clear,
  output logic          commit_done,
  output logic          cfg_err,
  input  logic [AW-1:0] rd_addr,
  output logic [IW+2:0] rd_data
);

  localparam int EW = IW + 3;

  state_t        state;
  logic [EW-1:0] shadow [NE];
  logic [EW-1:0] active [NE];
  logic [AW-1:0] clr_cnt;
  logic [2:0]    wr_side;
  logic [IW-1:0] wr_idx;
  logic          wr_ok;
  logic [NE-1:0] oe, val;

  assign cfg_ready = (state == ST_IDLE) && !rst;
  assign wr_side   = cfg_data[2:0];
  assign wr_idx    = cfg_data[EW-1:3];

  // An entry is legal if it names a real wire other than the one it drives.
  always_comb begin
    wr_ok = 1'b0;
    if (int'(cfg_addr) < NE) begin
      case (wr_side)
        SIDE_FLOAT:  wr_ok = 1'b1;
        SIDE_TOP:    wr_ok = (int'(wr_idx) < NT) && (int'(cfg_addr) != int'(wr_idx));
        SIDE_BOTTOM: wr_ok = (int'(wr_idx) < NT) && (int'(cfg_addr) != NT + int'(wr_idx));
        SIDE_LEFT:   wr_ok = (int'(wr_idx) < NL) && (int'(cfg_addr) != 2*NT + int'(wr_idx));
        SIDE_RIGHT:  wr_ok = (int'(wr_idx) < NL) && (int'(cfg_addr) != 2*NT + NL + int'(wr_idx));
        default:     wr_ok = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      clr_cnt     <= '0;
      commit_done <= 1'b0;
      cfg_err     <= 1'b0;
      rd_data     <= '0;
      for (int i = 0; i < NE; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      commit_done <= 1'b0;
      rd_data     <= (int'(rd_addr) < NE) ? active[rd_addr] : '0;
      case (state)
        ST_IDLE: begin
          if (cfg_valid) begin
            if (wr_ok) shadow[cfg_addr] <= cfg_data;
            else       cfg_err <= 1'b1;
          end
          // Clear wins over commit when both are requested together.
          if (cfg_clear) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end else if (cfg_commit) begin
            state <= ST_COMMIT;
          end
        end
        ST_CLEAR: begin
          shadow[clr_cnt] <= '0;
          if (int'(clr_cnt) == NE - 1) state <= ST_IDLE;
          else                         clr_cnt <= clr_cnt + 1'b1;
        end
        ST_COMMIT: begin
          for (int i = 0; i < NE; i++) active[i] <= shadow[i];
          commit_done <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar e = 0; e < NE; e++) begin : g_mux
    switch_matrix_mux #(.NT(NT), .NL(NL), .IW(IW)) u_mux (
      .sel    (active[e]),
      .top    (wtop),
      .bottom (wbottom),
      .left   (wleft),
      .right  (wright),
      .oe     (oe[e]),
      .val    (val[e])
    );
  end

  for (genvar i = 0; i < NT; i++) begin : g_tb_drv
    assign wtop[i]    = oe[i]      ? val[i]      : 1'bz;
    assign wbottom[i] = oe[NT + i] ? val[NT + i] : 1'bz;
  end

  for (genvar i = 0; i < NL; i++) begin : g_lr_drv
    assign wleft[i]  = oe[2*NT + i]      ? val[2*NT + i]      : 1'bz;
    assign wright[i] = oe[2*NT + NL + i] ? val[2*NT + NL + i] : 1'bz;
  end

endmodule

// File: doc/switch_matrix_cfg.md
SWITCH_MATRIX_CFG -- requirements
Module: switch_matrix_cfg

Interface
REQ-001 The block SHALL expose parameter NT, default 5, number of wires on each of the top and bottom sides.
REQ-002 The block SHALL expose parameter NL, default 4, number of wires on each of the left and right sides.
REQ-003 The block SHALL expose derived parameter IW, default clog2(max(NT,NL)) (3 at defaults), wire-index width.
REQ-004 The block SHALL expose derived parameter NE, default 2*NT+2*NL (18 at defaults), number of config entries; AW = clog2(NE).
REQ-005 The block SHALL have one clock and an asynchronous active-high reset, stated as: clk  input  1  rising-edge clock; rst  input  1  asynchronous, active-high reset.
REQ-006 wtop  inout  NT  top-side routed wires.
REQ-007 wbottom  inout  NT  bottom-side routed wires.
REQ-008 wleft  inout  NL  left-side routed wires.
REQ-009 wright  inout  NL  right-side routed wires.
REQ-010 cfg_valid  input  1  config write request.
REQ-011 cfg_ready  output  1  write/command accepted this cycle when high.
REQ-012 cfg_addr  input  AW  entry index: top 0..NT-1, bottom NT..2NT-1, left 2NT..2NT+NL-1, right 2NT+NL..NE-1.
REQ-013 cfg_data  input  IW+3  entry value: [2:0] source side (0 float, 1 top, 2 right, 3 bottom, 4 left), [IW+2:3] source index.
REQ-014 cfg_commit  input  1  request copy of shadow table into active table.
REQ-015 cfg_clear  input  1  request zeroing of shadow table.
REQ-016 commit_done  output  1  one-cycle pulse after active table updated.
REQ-017 cfg_err  output  1  sticky flag, set on any rejected write.
REQ-018 rd_addr  input  AW  active-table readback address; rd_data  output  IW+3  registered readback.

Function
REQ-019 Each wire SHALL be driven from the active-table entry at its address: side code 1-4 drives the wire with the selected side/index wire; code 0 or invalid drives high-impedance.
REQ-020 Routing SHALL be combinational from the active table; no wire changes except on commit or reset.
REQ-021 The FSM SHALL have states IDLE, CLEAR, COMMIT; cfg_ready = (state == IDLE) and not in reset.
REQ-022 In IDLE, cfg_valid with cfg_ready SHALL write cfg_data into shadow[cfg_addr] at that edge.
REQ-023 A write SHALL be rejected, with shadow unchanged and cfg_err set, if: cfg_addr >= NE; side code > 4; index >= NT for sides 1/3; index >= NL for sides 2/4; or the entry selects its own wire.
REQ-024 IDLE with cfg_commit SHALL go to COMMIT; COMMIT SHALL copy all NE shadow entries to active in one cycle, return to IDLE, and pulse commit_done on the following cycle.
REQ-025 IDLE with cfg_clear SHALL go to CLEAR; CLEAR SHALL zero one shadow entry per cycle with counter 0..NE-1, then return to IDLE, taking NE cycles (18 at defaults).
REQ-026 Write and cfg_commit in the same IDLE cycle SHALL accept the write, and the commit SHALL include it.
REQ-027 cfg_clear and cfg_commit together in IDLE SHALL select CLEAR; commit is dropped. A write in the same cycle is still accepted, then cleared.
REQ-028 cfg_valid, cfg_commit and cfg_clear SHALL be ignored outside IDLE.
REQ-029 The active table SHALL NOT be modified by CLEAR.
REQ-030 rd_data SHALL equal active[rd_addr] one cycle after rd_addr is presented; rd_data = 0 for rd_addr >= NE.
REQ-031 cfg_err SHALL clear only on reset.

Reset
REQ-032 rst SHALL asynchronously force: shadow and active tables all zero (all wires high-impedance), state IDLE, clear counter 0, commit_done 0, cfg_err 0, rd_data 0, cfg_ready 0 while rst is high.
REQ-033 rst asserted mid-CLEAR or mid-COMMIT SHALL abort the operation, with no partial state retained.

Structure
REQ-034 Side-code constants (FLOAT, TOP, RIGHT, BOTTOM, LEFT) and the FSM state encoding SHALL live in shared package switch_matrix_pkg.
REQ-035 The per-wire source mux SHALL be a sub-module, switch_matrix_mux, instantiated NE times.

Verification
REQ-036 Reset, then read all 18 active entries -> every rd_data = 0, all 18 wires read 'z'.
REQ-037 Write shadow[0] = {idx 2, side 4}, commit, drive wleft[2] = 1 -> commit_done pulses once, wtop[0] = 1; before commit wtop[0] = z.
REQ-038 Write addr 18, then side 5, then {idx 4, side 2}, then addr 0 = {idx 0, side 1} -> each rejected, shadow unchanged, cfg_err = 1 and stays set.
REQ-039 Write addr 11 = {idx 1, side 3} and assert cfg_commit in the same cycle -> after commit_done, rd_data at 11 = 6'b001011.
REQ-040 Configure entries, commit, cfg_clear -> cfg_ready low for exactly 18 cycles, active table unchanged; a following commit -> all wires z.
REQ-041 Assert rst 5 cycles into CLEAR -> immediate IDLE, tables zero, cfg_ready high on the first edge after rst falls.
